// File: rtl/scp_halt_monitor.sv
// Run/halt monitor: snoops register-file writes against programmable watch
// channels and halts on the first match or on a RUN-cycle timeout.
module scp_halt_monitor #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  go,
  input  logic                  clr,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH*REG_AW-1:0] watch_addr,
  input  logic [NCH*DATA_W-1:0] watch_val,
  input  logic                  wr_en,
  input  logic [REG_AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [PC_W-1:0]       pc,
  output logic                  running,
  output logic                  halted,
  output logic                  timed_out,
  output logic [CH_W-1:0]       hit_ch,
  output logic [PC_W-1:0]       halt_pc,
  output logic [CNT_W-1:0]      halt_cycle,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timed_q, timed_d;
  logic [CH_W-1:0]   hit_q, hit_d;
  logic [PC_W-1:0]   hpc_q, hpc_d;
  logic [CNT_W-1:0]  hcyc_q, hcyc_d;

  logic [NCH-1:0]    match;
  logic              any_match;
  logic [CH_W-1:0]   match_idx;
  logic              timeout_hit;

  // r0 writes are discarded by the regfile, so they can never match.
  always_comb begin
    match     = '0;
    match_idx = '0;
    any_match = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      match[k] = wr_en && ch_en[k] && (wr_addr != '0)
              && (wr_addr == watch_addr[k*REG_AW +: REG_AW])
              && (wr_data == watch_val[k*DATA_W +: DATA_W]);
      if (match[k] && !any_match) begin
        match_idx = CH_W'(k);
        any_match = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timed_d = timed_q;
    hit_d   = hit_q;
    hpc_d   = hpc_q;
    hcyc_d  = hcyc_q;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      timed_d = 1'b0;
      hit_d   = '0;
      hpc_d   = '0;
      hcyc_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (any_match) begin
            state_d = S_HALTED;
            hit_d   = match_idx;
            timed_d = 1'b0;
            hpc_d   = pc;
            hcyc_d  = cnt_q;
          end else if (timeout_hit) begin
            state_d = S_HALTED;
            hit_d   = '0;
            timed_d = 1'b1;
            hpc_d   = pc;
            hcyc_d  = cnt_q;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HALTED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timed_q <= 1'b0;
      hit_q   <= '0;
      hpc_q   <= '0;
      hcyc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timed_q <= timed_d;
      hit_q   <= hit_d;
      hpc_q   <= hpc_d;
      hcyc_q  <= hcyc_d;
    end
  end

  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALTED);
  assign timed_out   = timed_q;
  assign hit_ch      = hit_q;
  assign halt_pc     = hpc_q;
  assign halt_cycle  = hcyc_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_scp_halt_monitor.sv
// Directed bench for scp_halt_monitor (NCH=2, TIMEOUT=100).
module tb_scp_halt_monitor;

  logic        clk;
  logic        res;
  logic        go;
  logic        clr;
  logic [1:0]  ch_en;
  logic [9:0]  watch_addr;
  logic [63:0] watch_val;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc;
  logic        running;
  logic        halted;
  logic        timed_out;
  logic        hit_ch;
  logic [31:0] halt_pc;
  logic [31:0] halt_cycle;
  logic [31:0] cycle_count;

  int total = 0;
  int bad   = 0;

  scp_halt_monitor #(
    .NCH(2), .DATA_W(32), .REG_AW(5), .PC_W(32), .CNT_W(32), .TIMEOUT(100)
  ) dut (
    .clk(clk), .res(res), .go(go), .clr(clr), .ch_en(ch_en),
    .watch_addr(watch_addr), .watch_val(watch_val),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pc(pc),
    .running(running), .halted(halted), .timed_out(timed_out),
    .hit_ch(hit_ch), .halt_pc(halt_pc), .halt_cycle(halt_cycle),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".running"}, 64'(running), 64'd0);
    chk({tag, ".halted"}, 64'(halted), 64'd0);
    chk({tag, ".timed_out"}, 64'(timed_out), 64'd0);
    chk({tag, ".hit_ch"}, 64'(hit_ch), 64'd0);
    chk({tag, ".halt_pc"}, 64'(halt_pc), 64'd0);
    chk({tag, ".halt_cycle"}, 64'(halt_cycle), 64'd0);
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    wr_en = 1'b1; wr_addr = a; wr_data = d; pc = p;
  endtask

  initial begin
    res = 1'b0; go = 1'b0; clr = 1'b0; ch_en = 2'b01;
    watch_addr = {5'd0, 5'd8};
    watch_val  = {32'd0, 32'd1};
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc = '0;
    #12;
    chk_zero("reset");
    res = 1'b1;
    tick();

    // write r8=1 while IDLE
    wr(5'd8, 32'd1, 32'h10);
    tick();
    wr_en = 1'b0;
    chk("idle_match.halted", 64'(halted), 64'd0);
    chk("idle_match.running", 64'(running), 64'd0);

    // go, then r0 write with a channel watching r0==0
    go = 1'b1; tick(); go = 1'b0;
    chk("go.running", 64'(running), 64'd1);
    chk("go.cycle_count", 64'(cycle_count), 64'd0);
    repeat (5) tick();
    ch_en = 2'b11;
    wr(5'd0, 32'd0, 32'h20);
    tick();
    wr_en = 1'b0; ch_en = 2'b01;
    chk("r0.running", 64'(running), 64'd1);
    chk("r0.halted", 64'(halted), 64'd0);
    repeat (31) tick();
    chk("c37.cycle_count", 64'(cycle_count), 64'd37);
    wr(5'd8, 32'd1, 32'h94);
    tick();
    wr_en = 1'b0;
    chk("m37.halted", 64'(halted), 64'd1);
    chk("m37.running", 64'(running), 64'd0);
    chk("m37.hit_ch", 64'(hit_ch), 64'd0);
    chk("m37.timed_out", 64'(timed_out), 64'd0);
    chk("m37.halt_pc", 64'(halt_pc), 64'h94);
    chk("m37.halt_cycle", 64'(halt_cycle), 64'd37);
    chk("m37.cycle_count", 64'(cycle_count), 64'd37);

    // go and a fresh match while HALTED are ignored
    go = 1'b1;
    wr(5'd8, 32'd1, 32'h200);
    tick(); tick();
    go = 1'b0; wr_en = 1'b0;
    chk("hgo.halted", 64'(halted), 64'd1);
    chk("hgo.running", 64'(running), 64'd0);
    chk("hgo.halt_pc", 64'(halt_pc), 64'h94);
    chk("hgo.halt_cycle", 64'(halt_cycle), 64'd37);
    chk("hgo.cycle_count", 64'(cycle_count), 64'd37);

    clr = 1'b1; tick(); clr = 1'b0;
    chk_zero("clr");

    // priority: both channels watch r3==5
    watch_addr = {5'd3, 5'd3};
    watch_val  = {32'd5, 32'd5};
    ch_en = 2'b11;
    go = 1'b1; tick(); go = 1'b0;
    repeat (3) tick();
    wr(5'd3, 32'd5, 32'h40);
    tick();
    wr_en = 1'b0;
    chk("prio.halted", 64'(halted), 64'd1);
    chk("prio.hit_ch", 64'(hit_ch), 64'd0);
    chk("prio.halt_pc", 64'(halt_pc), 64'h40);
    chk("prio.halt_cycle", 64'(halt_cycle), 64'd3);

    // clr and go together: clr wins
    clr = 1'b1; go = 1'b1; tick(); clr = 1'b0; go = 1'b0;
    chk("clrgo.running", 64'(running), 64'd0);
    chk("clrgo.halted", 64'(halted), 64'd0);
    tick();
    chk("clrgo.idle", 64'(running), 64'd0);

    // channel 1 only; go during RUN does not restart the counter
    ch_en = 2'b10;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    go = 1'b1; tick(); go = 1'b0;
    chk("rungo.cycle_count", 64'(cycle_count), 64'd2);
    wr(5'd3, 32'd5, 32'h44);
    tick();
    wr_en = 1'b0;
    chk("ch1.hit_ch", 64'(hit_ch), 64'd1);
    chk("ch1.halt_cycle", 64'(halt_cycle), 64'd2);
    chk("ch1.halt_pc", 64'(halt_pc), 64'h44);
    clr = 1'b1; tick(); clr = 1'b0;

    // timeout with no matching write
    ch_en = 2'b00;
    go = 1'b1; tick(); go = 1'b0;
    repeat (98) tick();
    chk("to98.cycle_count", 64'(cycle_count), 64'd98);
    tick();
    chk("to99.running", 64'(running), 64'd1);
    pc = 32'h300;
    tick();
    chk("to.halted", 64'(halted), 64'd1);
    chk("to.timed_out", 64'(timed_out), 64'd1);
    chk("to.hit_ch", 64'(hit_ch), 64'd0);
    chk("to.halt_cycle", 64'(halt_cycle), 64'd99);
    chk("to.halt_pc", 64'(halt_pc), 64'h300);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("toclr.timed_out", 64'(timed_out), 64'd0);

    // match exactly on the timeout cycle
    ch_en = 2'b10;
    go = 1'b1; tick(); go = 1'b0;
    repeat (99) tick();
    wr(5'd3, 32'd5, 32'h304);
    tick();
    wr_en = 1'b0;
    chk("tom.halted", 64'(halted), 64'd1);
    chk("tom.timed_out", 64'(timed_out), 64'd0);
    chk("tom.hit_ch", 64'(hit_ch), 64'd1);
    chk("tom.halt_cycle", 64'(halt_cycle), 64'd99);
    chk("tom.halt_pc", 64'(halt_pc), 64'h304);

    // asynchronous reset while HALTED clears the capture
    #2 res = 1'b0;
    #1 chk_zero("hres");
    #1 res = 1'b1;
    tick();

    // asynchronous reset at RUN cycle 20
    ch_en = 2'b00;
    go = 1'b1; tick(); go = 1'b0;
    repeat (20) tick();
    chk("r20.cycle_count", 64'(cycle_count), 64'd20);
    #2 res = 1'b0;
    #1 chk_zero("rres");
    #1 res = 1'b1;
    tick(); tick();
    chk_zero("postres");
    go = 1'b1; tick(); go = 1'b0;
    tick();
    chk("regot.running", 64'(running), 64'd1);
    chk("regot.cycle_count", 64'(cycle_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
